// File: rtl/boot_rom_loader_pkg.sv
// Shared types and constants for the boot ROM loader: FSM encoding and write-port constants.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 16
`endif

package boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [3:0] BE_FULL    = 4'hF;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/boot_rom_loader_if.sv
// Bundle of the loader's ROM read port, RAM write port, start request and status outputs.
interface boot_rom_loader_if #(
  parameter int ROM_AW = `ROM_ADDR_WIDTH,
  parameter int MEM_AW = 32,
  parameter int DW     = 32
);

  logic              start_i;
  logic              rom_en_o;
  logic [ROM_AW-1:0] rom_addr_o;
  logic [DW-1:0]     rom_rdata_i;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              mem_gnt_i;
  logic              busy_o;
  logic              done_o;
  logic              fetch_en_o;
  logic [31:0]       checksum_o;

  modport master (
    input  start_i, rom_rdata_i, mem_gnt_i,
    output rom_en_o, rom_addr_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
           mem_wdata_o, busy_o, done_o, fetch_en_o, checksum_o
  );

  modport slave (
    output start_i, rom_rdata_i, mem_gnt_i,
    input  rom_en_o, rom_addr_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
           mem_wdata_o, busy_o, done_o, fetch_en_o, checksum_o
  );

endinterface

// File: rtl/boot_rom_loader.sv
// Copies NUM_WORDS words from the boot ROM into instruction RAM, sums them, then
// raises fetch enable so the core can start.
//
// state  | meaning
// IDLE   | waiting for auto-start or start_i
// RD     | ROM read enable for word[index]
// CAP    | ROM data valid: capture and accumulate checksum
// WR     | RAM write request held until grant
// DONE   | copy complete, fetch enable released (sticky until reset)
module boot_rom_loader
  import boot_loader_pkg::*;
#(
  parameter int          ROM_ADDR_WIDTH = `ROM_ADDR_WIDTH,
  parameter int          MEM_ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          NUM_WORDS      = 256,
  parameter logic [31:0] SRC_BASE       = 32'h0000_0000,
  parameter logic [31:0] DST_BASE       = 32'h0000_8000,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  boot_rom_loader_if.master bus
);

  localparam int IW = (NUM_WORDS < 1) ? 1 : $clog2(NUM_WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'((NUM_WORDS == 0) ? 0 : NUM_WORDS - 1);
  localparam logic [ROM_ADDR_WIDTH-1:0] ROM_BASE = ROM_ADDR_WIDTH'(SRC_BASE);
  localparam logic [MEM_ADDR_WIDTH-1:0] MEM_BASE = MEM_ADDR_WIDTH'(DST_BASE);

  state_e                    state_q, state_d;
  logic [IW-1:0]             index_q, index_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [31:0]               checksum_q, checksum_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_word_addr;
  logic [MEM_ADDR_WIDTH-1:0] mem_word_addr;
  logic                      in_rd;
  logic                      in_wr;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    data_d     = data_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (AUTO_START || bus.start_i) begin
          state_d = (NUM_WORDS == 0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        data_d     = bus.rom_rdata_i;
        checksum_d = checksum_q + 32'(bus.rom_rdata_i);
        state_d    = S_WR;
      end
      S_WR: begin
        // Request stays up until granted; the grant cycle is the last request cycle.
        if (bus.mem_gnt_i) begin
          if (index_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + IW'(1);
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      data_q     <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      data_q     <= data_d;
      checksum_q <= checksum_d;
    end
  end

  // Both address generators wrap silently at their port width.
  assign rom_word_addr = ROM_BASE + ROM_ADDR_WIDTH'(index_q) * ROM_ADDR_WIDTH'(WORD_BYTES);
  assign mem_word_addr = MEM_BASE + MEM_ADDR_WIDTH'(index_q) * MEM_ADDR_WIDTH'(WORD_BYTES);

  assign in_rd = (state_q == S_RD);
  assign in_wr = (state_q == S_WR);

  assign bus.rom_en_o    = in_rd;
  assign bus.rom_addr_o  = in_rd ? rom_word_addr : '0;
  assign bus.mem_req_o   = in_wr;
  assign bus.mem_we_o    = in_wr;
  assign bus.mem_be_o    = in_wr ? BE_FULL : 4'h0;
  assign bus.mem_addr_o  = in_wr ? mem_word_addr : '0;
  assign bus.mem_wdata_o = in_wr ? data_q : '0;
  assign bus.busy_o      = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.fetch_en_o  = (state_q == S_DONE);
  assign bus.checksum_o  = checksum_q;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Directed bench for boot_rom_loader: four configurations sharing one clock.
module tb_boot_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a: auto, 4 words   b: manual, 2 words   c: auto, 8 words   d: manual, 0 words
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
  logic gnt_a = 1'b1, gnt_b = 1'b1, gnt_c = 1'b1, gnt_d = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic [31:0] rdata_a = '0, rdata_b = '0, rdata_c = '0;
  logic [31:0] rom_a [4];
  logic [31:0] rom_b [4];
  logic [31:0] rom_c [8];

  boot_rom_loader_if #(.ROM_AW(16)) bus_a ();
  boot_rom_loader_if #(.ROM_AW(16)) bus_b ();
  boot_rom_loader_if #(.ROM_AW(16)) bus_c ();
  boot_rom_loader_if #(.ROM_AW(16)) bus_d ();

  boot_rom_loader #(.ROM_ADDR_WIDTH(16), .NUM_WORDS(4), .AUTO_START(1'b1))
    u_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  boot_rom_loader #(.ROM_ADDR_WIDTH(16), .NUM_WORDS(2), .AUTO_START(1'b0))
    u_b (.clk(clk), .rst(rst_b), .bus(bus_b));
  boot_rom_loader #(.ROM_ADDR_WIDTH(16), .NUM_WORDS(8), .AUTO_START(1'b1))
    u_c (.clk(clk), .rst(rst_c), .bus(bus_c));
  boot_rom_loader #(.ROM_ADDR_WIDTH(16), .NUM_WORDS(0), .AUTO_START(1'b0))
    u_d (.clk(clk), .rst(rst_d), .bus(bus_d));

  assign bus_a.start_i = start_a;  assign bus_a.mem_gnt_i = gnt_a;  assign bus_a.rom_rdata_i = rdata_a;
  assign bus_b.start_i = start_b;  assign bus_b.mem_gnt_i = gnt_b;  assign bus_b.rom_rdata_i = rdata_b;
  assign bus_c.start_i = start_c;  assign bus_c.mem_gnt_i = gnt_c;  assign bus_c.rom_rdata_i = rdata_c;
  assign bus_d.start_i = start_d;  assign bus_d.mem_gnt_i = gnt_d;  assign bus_d.rom_rdata_i = 32'h0;

  // ROM models return data the cycle after enable; write/read logs record completed transfers.
  logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$], wc_addr[$], wc_data[$];
  logic [15:0] rc_addr[$];
  int rom_cnt_b = 0, rom_cnt_d = 0, wr_cnt_d = 0;

  always @(posedge clk) begin
    if (bus_a.rom_en_o) rdata_a <= rom_a[bus_a.rom_addr_o[3:2]];
    if (bus_b.rom_en_o) rdata_b <= rom_b[bus_b.rom_addr_o[3:2]];
    if (bus_c.rom_en_o) rdata_c <= rom_c[bus_c.rom_addr_o[4:2]];
    if (bus_a.mem_req_o && bus_a.mem_gnt_i) begin
      wa_addr.push_back(bus_a.mem_addr_o); wa_data.push_back(bus_a.mem_wdata_o);
    end
    if (bus_b.mem_req_o && bus_b.mem_gnt_i) begin
      wb_addr.push_back(bus_b.mem_addr_o); wb_data.push_back(bus_b.mem_wdata_o);
    end
    if (bus_c.mem_req_o && bus_c.mem_gnt_i) begin
      wc_addr.push_back(bus_c.mem_addr_o); wc_data.push_back(bus_c.mem_wdata_o);
    end
    if (bus_c.rom_en_o) rc_addr.push_back(bus_c.rom_addr_o);
    if (bus_b.rom_en_o) rom_cnt_b++;
    if (bus_d.rom_en_o) rom_cnt_d++;
    if (bus_d.mem_req_o) wr_cnt_d++;
  end

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus_a.rom_en_o, bus_a.mem_req_o, bus_a.mem_we_o, bus_a.busy_o, bus_a.done_o, bus_a.fetch_en_o} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {bus_a.rom_en_o, bus_a.mem_req_o,
        bus_a.mem_we_o, bus_a.busy_o, bus_a.done_o, bus_a.fetch_en_o});
    end
    total++;
    if ({bus_a.rom_addr_o, bus_a.mem_addr_o, bus_a.mem_wdata_o, bus_a.mem_be_o} !== 84'h0) begin
      bad++; $display("FAIL reset_bus: rom_addr=%h mem_addr=%h wdata=%h be=%h want all 0",
        bus_a.rom_addr_o, bus_a.mem_addr_o, bus_a.mem_wdata_o, bus_a.mem_be_o);
    end
    total++;
    if (bus_a.checksum_o !== 32'h0) begin
      bad++; $display("FAIL reset_checksum: got %h want 0", bus_a.checksum_o);
    end
  endtask

  task automatic restart_a();
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    wa_addr.delete(); wa_data.delete();
    rst_a = 1'b0;
  endtask

  task automatic test_basic_copy();
    int cyc;
    int side_err;
    rom_a[0] = 32'd1; rom_a[1] = 32'd2; rom_a[2] = 32'd3; rom_a[3] = 32'd4;
    gnt_a = 1'b1;
    restart_a();
    cyc = 0; side_err = 0;
    while (!bus_a.done_o && cyc < 100) begin
      @(negedge clk); cyc++;
      if (bus_a.mem_req_o && (bus_a.mem_be_o !== 4'hF || bus_a.mem_we_o !== 1'b1)) side_err++;
      if (!bus_a.mem_req_o && (bus_a.mem_be_o !== 4'h0 || bus_a.mem_addr_o !== 32'h0 || bus_a.mem_wdata_o !== 32'h0)) side_err++;
      if (!bus_a.rom_en_o && bus_a.rom_addr_o !== 16'h0) side_err++;
    end
    total++;
    if (cyc != 13) begin bad++; $display("FAIL basic_latency: got %0d cycles want 13", cyc); end
    total++;
    if (side_err != 0) begin bad++; $display("FAIL basic_side_signals: got %0d bad cycles want 0", side_err); end
    total++;
    if (bus_a.checksum_o !== 32'd10) begin bad++; $display("FAIL basic_checksum: got %h want 0000000a", bus_a.checksum_o); end
    total++;
    if (bus_a.fetch_en_o !== 1'b1 || bus_a.busy_o !== 1'b0) begin
      bad++; $display("FAIL basic_status: fetch_en=%b busy=%b want 1 0", bus_a.fetch_en_o, bus_a.busy_o);
    end
    total++;
    if (wa_addr.size() != 4) begin
      bad++; $display("FAIL basic_write_count: got %0d want 4", wa_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wa_addr[i] !== 32'h8000 + 32'(4 * i) || wa_data[i] !== 32'(i + 1)) begin
          bad++; $display("FAIL basic_write%0d: got %h/%h want %h/%h", i, wa_addr[i], wa_data[i],
            32'h8000 + 32'(4 * i), 32'(i + 1));
        end
      end
    end
  endtask

  task automatic test_grant_stall();
    int cyc, stall_left, hold_err;
    bit stalled;
    rom_a[0] = 32'd1; rom_a[1] = 32'd2; rom_a[2] = 32'd3; rom_a[3] = 32'd4;
    gnt_a = 1'b1;
    restart_a();
    cyc = 0; stall_left = 0; stalled = 0; hold_err = 0;
    while (!bus_a.done_o && cyc < 100) begin
      @(negedge clk); cyc++;
      if (stall_left > 0) begin
        if (bus_a.mem_req_o !== 1'b1 || bus_a.mem_addr_o !== 32'h8004 ||
            bus_a.mem_wdata_o !== 32'd2 || bus_a.rom_en_o !== 1'b0) hold_err++;
        stall_left--;
        if (stall_left == 0) gnt_a = 1'b1;
      end else if (!stalled && bus_a.mem_req_o && bus_a.mem_addr_o == 32'h8004) begin
        gnt_a = 1'b0; stall_left = 5; stalled = 1;
      end
    end
    total++;
    if (!stalled || hold_err != 0) begin
      bad++; $display("FAIL stall_hold: stalled=%0d bad cycles=%0d want 1 0", stalled, hold_err);
    end
    total++;
    if (cyc != 18) begin bad++; $display("FAIL stall_latency: got %0d cycles want 18", cyc); end
    total++;
    if (wa_addr.size() != 4 || bus_a.checksum_o !== 32'd10) begin
      bad++; $display("FAIL stall_result: writes=%0d checksum=%h want 4 0000000a", wa_addr.size(), bus_a.checksum_o);
    end
  endtask

  task automatic test_checksum_wrap();
    int cyc;
    rom_a[0] = 32'hFFFF_FFFF; rom_a[1] = 32'h0000_0002; rom_a[2] = 32'h0; rom_a[3] = 32'h0;
    gnt_a = 1'b1;
    restart_a();
    cyc = 0;
    while (!bus_a.done_o && cyc < 100) begin @(negedge clk); cyc++; end
    total++;
    if (bus_a.checksum_o !== 32'h0000_0001) begin
      bad++; $display("FAIL checksum_wrap: got %h want 00000001", bus_a.checksum_o);
    end
  endtask

  task automatic test_manual_start();
    int cyc;
    rom_b[0] = 32'hA5A5_0001; rom_b[1] = 32'h1234_5678; rom_b[2] = 32'h0; rom_b[3] = 32'h0;
    @(negedge clk); rst_b = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (bus_b.busy_o !== 1'b0 || bus_b.done_o !== 1'b0 || rom_cnt_b != 0 || wb_addr.size() != 0) begin
      bad++; $display("FAIL manual_idle: busy=%b done=%b reads=%0d writes=%0d want 0 0 0 0",
        bus_b.busy_o, bus_b.done_o, rom_cnt_b, wb_addr.size());
    end
    cyc = 0; start_b = 1'b1;
    while (!bus_b.done_o && cyc < 100) begin
      @(negedge clk); cyc++;
      start_b = (cyc == 3);
    end
    start_b = 1'b0;
    total++;
    if (cyc != 7) begin bad++; $display("FAIL manual_latency: got %0d cycles want 7", cyc); end
    total++;
    if (wb_addr.size() != 2) begin
      bad++; $display("FAIL manual_write_count: got %0d want 2", wb_addr.size());
    end else begin
      total++;
      if (wb_addr[0] !== 32'h8000 || wb_data[0] !== 32'hA5A5_0001 ||
          wb_addr[1] !== 32'h8004 || wb_data[1] !== 32'h1234_5678) begin
        bad++; $display("FAIL manual_writes: got %h/%h %h/%h want 00008000/a5a50001 00008004/12345678",
          wb_addr[0], wb_data[0], wb_addr[1], wb_data[1]);
      end
    end
    total++;
    if (bus_b.checksum_o !== 32'hB7D9_5679) begin
      bad++; $display("FAIL manual_checksum: got %h want b7d95679", bus_b.checksum_o);
    end
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (bus_b.done_o !== 1'b1 || bus_b.busy_o !== 1'b0 || rom_cnt_b != 2 || wb_addr.size() != 2) begin
      bad++; $display("FAIL manual_start_after_done: done=%b busy=%b reads=%0d writes=%0d want 1 0 2 2",
        bus_b.done_o, bus_b.busy_o, rom_cnt_b, wb_addr.size());
    end
  endtask

  task automatic test_reset_mid_copy();
    int cyc;
    for (int i = 0; i < 8; i++) rom_c[i] = 32'(10 * (i + 1));
    @(negedge clk); rst_c = 1'b0;
    cyc = 0;
    while (!(bus_c.mem_req_o && bus_c.mem_addr_o == 32'h8008) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    total++;
    if (cyc >= 100 || wc_addr.size() != 2) begin
      bad++; $display("FAIL midreset_reach_word3: cycles=%0d writes=%0d want <100 2", cyc, wc_addr.size());
    end
    #2 rst_c = 1'b1;
    #1;
    total++;
    if ({bus_c.rom_en_o, bus_c.mem_req_o, bus_c.mem_we_o, bus_c.busy_o, bus_c.done_o,
         bus_c.mem_be_o, bus_c.mem_addr_o, bus_c.mem_wdata_o, bus_c.checksum_o} !== 105'h0) begin
      bad++; $display("FAIL midreset_async_clear: req=%b addr=%h wdata=%h busy=%b checksum=%h want all 0",
        bus_c.mem_req_o, bus_c.mem_addr_o, bus_c.mem_wdata_o, bus_c.busy_o, bus_c.checksum_o);
    end
    repeat (2) @(negedge clk);
    wc_addr.delete(); wc_data.delete(); rc_addr.delete();
    rst_c = 1'b0;
    cyc = 0;
    while (!bus_c.done_o && cyc < 200) begin @(negedge clk); cyc++; end
    total++;
    if (cyc != 25) begin bad++; $display("FAIL midreset_latency: got %0d cycles want 25", cyc); end
    total++;
    if (bus_c.checksum_o !== 32'd360) begin
      bad++; $display("FAIL midreset_checksum: got %h want 00000168", bus_c.checksum_o);
    end
    total++;
    if (wc_addr.size() != 8 || rc_addr.size() != 8) begin
      bad++; $display("FAIL midreset_counts: writes=%0d reads=%0d want 8 8", wc_addr.size(), rc_addr.size());
    end else begin
      total++;
      if (rc_addr[0] !== 16'h0 || wc_addr[0] !== 32'h8000 || wc_data[0] !== 32'd10 ||
          rc_addr[7] !== 16'h001C || wc_addr[7] !== 32'h801C || wc_data[7] !== 32'd80) begin
        bad++; $display("FAIL midreset_restart_addrs: rom0=%h mem0=%h d0=%h rom7=%h mem7=%h d7=%h want 0000 00008000 0000000a 001c 0000801c 00000050",
          rc_addr[0], wc_addr[0], wc_data[0], rc_addr[7], wc_addr[7], wc_data[7]);
      end
    end
  endtask

  task automatic test_zero_words();
    @(negedge clk); rst_d = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus_d.done_o !== 1'b0) begin bad++; $display("FAIL zero_before_start: done=%b want 0", bus_d.done_o); end
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    total++;
    if (bus_d.done_o !== 1'b1 || bus_d.fetch_en_o !== 1'b1 || bus_d.busy_o !== 1'b0) begin
      bad++; $display("FAIL zero_done: done=%b fetch_en=%b busy=%b want 1 1 0",
        bus_d.done_o, bus_d.fetch_en_o, bus_d.busy_o);
    end
    repeat (5) @(negedge clk);
    total++;
    if (rom_cnt_d != 0 || wr_cnt_d != 0 || bus_d.checksum_o !== 32'h0 || bus_d.done_o !== 1'b1) begin
      bad++; $display("FAIL zero_no_activity: reads=%0d writes=%0d checksum=%h done=%b want 0 0 0 1",
        rom_cnt_d, wr_cnt_d, bus_d.checksum_o, bus_d.done_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
    for (int i = 0; i < 8; i++) rom_c[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_copy();
    test_grant_stall();
    test_checksum_wrap();
    test_manual_start();
    test_reset_mid_copy();
    test_zero_words();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_rom_loader.md
Name: boot_rom_loader

Overview:
- Initiator-side companion to the boot ROM wrapper.
- After reset, or on a start pulse, it reads NUM_WORDS consecutive 32-bit words from the boot ROM port and writes them into instruction RAM over a req/gnt memory port.
- It keeps a running 32-bit checksum and asserts fetch_en_o to release the core when the copy completes.
- Sits in the SoC between the boot ROM wrapper, the instruction-RAM interconnect port and the core's fetch-enable input.

Parameters:
ROM_ADDR_WIDTH, `ROM_ADDR_WIDTH, byte-address width of the ROM port; bits [1:0] are always driven 0
MEM_ADDR_WIDTH, 32, byte-address width of the memory port
DATA_WIDTH, 32, word width; fixed at 32
NUM_WORDS, 256, number of words copied; 0 allowed
SRC_BASE, 0, ROM byte address of the first word; word-aligned
DST_BASE, 32'h0000_8000, RAM byte address of the first word; word-aligned
AUTO_START, 1, 1 = copy starts automatically after reset deassertion; 0 = wait for start_i

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_i  in  1  single-cycle start request; honoured only in IDLE
rom_en_o  out  1  ROM read enable; the ROM returns data the cycle after enable
rom_addr_o  out  ROM_ADDR_WIDTH  ROM byte address
rom_rdata_i  in  DATA_WIDTH  ROM read data
mem_req_o  out  1  RAM write request
mem_we_o  out  1  RAM write enable; equals mem_req_o
mem_be_o  out  4  byte enables; 4'hF while mem_req_o=1, else 0
mem_addr_o  out  MEM_ADDR_WIDTH  RAM byte address
mem_wdata_o  out  DATA_WIDTH  RAM write data
mem_gnt_i  in  1  RAM grant; the write completes in the cycle where mem_req_o & mem_gnt_i
busy_o  out  1  copy in progress
done_o  out  1  copy finished; sticky until reset
fetch_en_o  out  1  core fetch enable; equals done_o
checksum_o  out  32  mod-2^32 sum of all words copied

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state = IDLE; all outputs 0; index = 0; checksum = 0; data register = 0.
- FSM states: IDLE, RD, CAP, WR, DONE.
- IDLE:
  - If AUTO_START=1, move to RD on the first clock after reset release.
  - Otherwise move to RD on start_i=1.
  - If NUM_WORDS=0, go directly to DONE.
- RD (1 cycle):
  - rom_en_o=1.
  - rom_addr_o = SRC_BASE + 4*index, truncated to ROM_ADDR_WIDTH; wraps silently.
  - Next state is CAP.
- CAP (1 cycle):
  - Register rom_rdata_i into the data register.
  - checksum += rom_rdata_i, mod 2^32.
  - Next state is WR.
- WR:
  - mem_req_o = mem_we_o = 1; mem_be_o = 4'hF.
  - mem_addr_o = DST_BASE + 4*index; mem_wdata_o = data register.
  - Address and data are held stable until grant; request is never withdrawn without grant.
  - On mem_gnt_i=1: if index == NUM_WORDS-1, go to DONE; else index++ and go to RD.
  - The grant cycle is the last cycle of mem_req_o.
- DONE:
  - done_o = fetch_en_o = 1, held until reset.
  - start_i is ignored.
- Control inputs:
  - busy_o = 1 in states RD, CAP and WR.
  - start_i in any state other than IDLE is ignored; it is not queued.
- Outputs outside active states:
  - rom_addr_o, mem_addr_o and mem_wdata_o are 0 whenever their enable/req is 0.
- Latency:
  - Minimum 3 cycles per word with grant in the first WR cycle.
  - Total = 3*NUM_WORDS + 1 cycles from start acceptance to done_o=1.
- Counter sizing:
  - index width = $clog2(NUM_WORDS+1), minimum 1.
- Reset mid-copy:
  - Immediate return to IDLE with all outputs 0; the partial RAM contents are left as written.
  - With AUTO_START=1 the copy restarts from word 0.
- A grant arriving while mem_req_o=0 is ignored.

Decomposition:
- boot_loader_pkg holds:
  - the state enum (IDLE, RD, CAP, WR, DONE)
  - BE_FULL = 4'hF
  - WORD_BYTES = 4
- No sub-module. The FSM, index counter, data register and checksum accumulator live in one module.

Test Plan:
- AUTO_START=1, NUM_WORDS=4, ROM words 1,2,3,4, gnt tied 1:
  - writes land at 0x8000, 0x8004, 0x8008, 0x800C with data 1..4
  - done_o rises 13 cycles after reset release; checksum_o = 10.
- Grant stalls: gnt low for 5 cycles on word 2:
  - mem_req_o, mem_addr_o = 0x8004 and data are held stable throughout
  - the next ROM read does not start until the grant
  - total time grows by exactly 5 cycles.
- AUTO_START=0, NUM_WORDS=2:
  - no activity until start_i
  - a start_i pulse while busy causes no restart and no extra writes
  - start_i after done is ignored.
- Checksum wrap: ROM words 0xFFFF_FFFF and 0x0000_0002 -> checksum_o = 0x0000_0001.
- Reset asserted in WR of word 3 of 8:
  - all outputs go 0 asynchronously
  - after release the copy restarts at SRC_BASE and DST_BASE, and the final checksum matches a clean run.
- NUM_WORDS=0:
  - done_o = fetch_en_o = 1 one cycle after start
  - rom_en_o and mem_req_o never assert; checksum_o = 0.
